sram_rw_port_arbiter: RTL

//   Shares one single-port RW SRAM macro (RW0_* port: en/wmode/wmask/wdata, registered read address,

---
 rtl/sram_arb_pkg.sv | 17 +
 rtl/sram_rr_pick.sv | 36 +++
 rtl/sram_rw_port_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and helpers for the SRAM RW port arbiter
package sram_arb_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_t;

  // Requester id width; never below 1 so a single requester still gets a legal vector.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/sram_rr_pick.sv
// rtl/sram_rr_pick.sv - round-robin one-hot picker starting the scan at ptr
module sram_rr_pick
  import sram_arb_pkg::*;
#(
  parameter int N    = 2,
  parameter int ID_W = clog2(N)
) (
  input  logic [N-1:0]    valid,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id,
  output logic            any
);

  // First pass covers ptr..N-1, second pass wraps to 0..ptr-1.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && valid[i] && (i >= int'(ptr))) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        grant_id = ID_W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!any && valid[i] && (i < int'(ptr))) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        grant_id = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/sram_rw_port_arbiter.sv
// rtl/sram_rw_port_arbiter.sv - round-robin sharing of one single-port RW SRAM macro
// Build option: define SRAM_ARB_INIT_EN for a zero sweep of the SRAM after every reset.
module sram_rw_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 256,
  parameter int MASK_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_wmode,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  input  logic [NREQ*MASK_W-1:0]   req_wmask,
  output logic [NREQ-1:0]          resp_valid,
  output logic [DATA_W-1:0]        resp_rdata,
  output logic                     sram_en,
  output logic                     sram_wmode,
  output logic [ADDR_W-1:0]        sram_addr,
  output logic [MASK_W-1:0]        sram_wmask,
  output logic [DATA_W-1:0]        sram_wdata,
  input  logic [DATA_W-1:0]        sram_rdata,
  output logic                     init_done
);

  localparam int ID_W = clog2(NREQ);

  logic [NREQ-1:0]   grant;
  logic [ID_W-1:0]   grant_id;
  logic              any_valid;
  logic              run_en;
  logic              fire;
  logic [ID_W-1:0]   rr_ptr;
  logic              rd_pend;
  logic [ID_W-1:0]   resp_id;
  logic              win_wmode;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [MASK_W-1:0] win_wmask;

`ifdef SRAM_ARB_INIT_EN
  arb_state_t        state;
  arb_state_t        state_nxt;
  logic [ADDR_W-1:0] init_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if ((state == ST_INIT) && (init_cnt == {ADDR_W{1'b1}})) begin
      state_nxt = ST_RUN;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      init_cnt <= init_cnt + 1'b1;
    end
  end

  assign run_en    = (state == ST_RUN);
  assign init_done = (state == ST_RUN);
`else
  assign run_en    = 1'b1;
  assign init_done = 1'b1;
`endif

  sram_rr_pick #(
    .N    (NREQ),
    .ID_W (ID_W)
  ) u_pick (
    .valid    (req_valid),
    .ptr      (rr_ptr),
    .grant    (grant),
    .grant_id (grant_id),
    .any      (any_valid)
  );

  assign fire      = run_en & any_valid;
  assign req_ready = grant & {NREQ{run_en}};

  // One-hot AND-OR select of the winner's request fields.
  always_comb begin
    win_wmode = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    win_wmask = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        win_wmode = req_wmode[i];
        win_addr  = req_addr[i*ADDR_W +: ADDR_W];
        win_wdata = req_wdata[i*DATA_W +: DATA_W];
        win_wmask = req_wmask[i*MASK_W +: MASK_W];
      end
    end
  end

  // Output process: SRAM port drive; the init sweep owns the port while it runs.
  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_wmask = '0;
    if (fire) begin
      sram_en    = 1'b1;
      sram_wmode = win_wmode;
      sram_addr  = win_addr;
      sram_wdata = win_wdata;
      sram_wmask = win_wmask;
    end
`ifdef SRAM_ARB_INIT_EN
    if (state == ST_INIT) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = init_cnt;
      sram_wdata = '0;
      sram_wmask = '1;
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr  <= '0;
      rd_pend <= 1'b0;
      resp_id <= '0;
    end else begin
      rd_pend <= fire & ~win_wmode;
      if (fire) begin
        rr_ptr  <= (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;
        resp_id <= grant_id;
      end
    end
  end

  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      resp_valid[i] = rd_pend && (resp_id == ID_W'(i));
    end
  end

  // Macro read data is valid exactly one cycle after the read, matching rd_pend.
  assign resp_rdata = sram_rdata;

endmodule
